// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory/MMIO block: register offsets,
// STATUS bit positions, UART state encoding and the store lane-steering helper.
package dmem_pkg;

  localparam logic [1:0] OFF_CYCLE_LO = 2'd0;
  localparam logic [1:0] OFF_CYCLE_HI = 2'd1;
  localparam logic [1:0] OFF_TXDATA   = 2'd2;
  localparam logic [1:0] OFF_STATUS   = 2'd3;

  localparam int STAT_BUSY = 0;
  localparam int STAT_OVF  = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // Replicate unshifted store data so every enabled lane sees the right byte/half.
  function automatic logic [31:0] steer_lanes(input logic [3:0] sel, input logic [31:0] d);
    logic [2:0] n;
    n = 3'(sel[0]) + 3'(sel[1]) + 3'(sel[2]) + 3'(sel[3]);
    case (n)
      3'd1:    return {4{d[7:0]}};
      3'd2:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx.sv
// Byte-wide 8N1 serial transmitter: start strobe loads a byte when idle,
// busy stays high from the start bit through the end of the stop bit.
module uart_tx
  import dmem_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       busy_o,
  output logic       tx_o
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);

  uart_state_e   state_q;
  logic [CW-1:0] tick_q;
  logic [2:0]    bit_q;
  logic [7:0]    data_q;
  logic          tx_q;
  logic          busy_q;

  logic period_end;
  assign period_end = (tick_q == LAST_TICK);

  // tx_q is loaded one bit ahead so the line changes exactly on period boundaries.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= START;
            data_q  <= data_i;
            tick_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (period_end) begin
            state_q <= DATA;
            tick_q  <= '0;
            tx_q    <= data_q[0];
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        DATA: begin
          if (period_end) begin
            tick_q <= '0;
            if (bit_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q <= bit_q + 3'd1;
              tx_q  <= data_q[bit_q + 3'd1];
            end
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        STOP: begin
          if (period_end) begin
            state_q <= IDLE;
            tick_q  <= '0;
            busy_q  <= 1'b0;
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o = busy_q;
  assign tx_o   = tx_q;

endmodule

// File: rtl/dmem_mmio.sv
// Data-memory stage target: byte-lane RAM with combinational read plus a 16-byte
// MMIO window (cycle counter, optional UART enabled by defining DMEM_UART_EN).
module dmem_mmio
  import dmem_pkg::*;
#(
  parameter int          DEPTH        = 1024,
  parameter logic [31:0] MMIO_BASE    = 32'hFFFF_0000,
  parameter int          CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  input  logic        we,
  input  logic [3:0]  wsel,
  output logic [31:0] rd,
  output logic        uart_tx
);

  localparam int AW = $clog2(DEPTH);

  logic          is_ram;
  logic          is_mmio;
  logic [AW-1:0] widx;
  logic [31:0]   lane_data;
  logic [31:0]   ram_word;
  logic [31:0]   status_word;
  logic [63:0]   cycle_q;
  logic [63:0]   cycle_d;

  assign is_ram    = (a[31:AW+2] == '0);
  assign is_mmio   = (a[31:4] == MMIO_BASE[31:4]);
  assign widx      = a[AW+1:2];
  assign lane_data = steer_lanes(wsel, wd);

  // One byte-wide array per lane; the core needs the read word in the same
  // cycle, so the read port is asynchronous.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (we && is_ram && wsel[gi]) begin
        mem[widx] <= lane_data[8*gi +: 8];
      end
    end

    assign ram_word[8*gi +: 8] = mem[widx];
  end

  assign cycle_d = cycle_q + 64'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q <= '0;
    end else begin
      cycle_q <= cycle_d;
    end
  end

`ifdef DMEM_UART_EN
  logic tx_wr;
  logic stat_wr;
  logic tx_busy;
  logic ovf_q;

  assign tx_wr   = we && is_mmio && (a[3:2] == OFF_TXDATA);
  assign stat_wr = we && is_mmio && (a[3:2] == OFF_STATUS);

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk    (clk),
    .reset  (reset),
    .start_i(tx_wr && !tx_busy),
    .data_i (wd[7:0]),
    .busy_o (tx_busy),
    .tx_o   (uart_tx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (tx_wr && tx_busy) begin
      ovf_q <= 1'b1;
    end else if (stat_wr && wd[STAT_OVF]) begin
      ovf_q <= 1'b0;
    end
  end

  always_comb begin
    status_word            = '0;
    status_word[STAT_BUSY] = tx_busy;
    status_word[STAT_OVF]  = ovf_q;
  end
`else
  logic unused_cfg;
  assign unused_cfg  = (CLKS_PER_BIT > 1);
  assign uart_tx     = 1'b1;
  assign status_word = '0;
`endif

  // Reads are side-effect free; unmapped addresses return zero.
  always_comb begin
    rd = '0;
    if (is_ram) begin
      rd = ram_word;
    end else if (is_mmio) begin
      case (a[3:2])
        OFF_CYCLE_LO: rd = cycle_q[31:0];
        OFF_CYCLE_HI: rd = cycle_q[63:32];
        OFF_STATUS:   rd = status_word;
        default:      rd = '0;
      endcase
    end
  end

  logic unused_addr;
  assign unused_addr = ^a[1:0];

endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio: directed and random RAM traffic against a
// byte-array model, cycle counter checks and UART frame/overflow/reset checks.
module tb_dmem_mmio;

  localparam int          DEPTH = 1024;
  localparam int          CPB   = 4;
  localparam logic [31:0] MB    = 32'hFFFF_0000;
  localparam int          NB    = DEPTH * 4;
`ifdef DMEM_UART_EN
  localparam bit UART_EN = 1'b1;
`else
  localparam bit UART_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a;
  logic [31:0] wd;
  logic        we;
  logic [3:0]  wsel;
  logic [31:0] rd;
  logic        uart_tx;

  dmem_mmio #(
    .DEPTH(DEPTH),
    .MMIO_BASE(MB),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .a(a),
    .wd(wd),
    .we(we),
    .wsel(wsel),
    .rd(rd),
    .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_chk = 0;
  int          n_fail = 0;
  int unsigned base_cyc;
  logic [7:0]  ref_b [NB];
  bit          known [NB];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit in_ram(input logic [31:0] addr);
    return addr < 32'(NB);
  endfunction

  function automatic bit known_word(input logic [31:0] addr);
    int b;
    if (!in_ram(addr)) return 1'b1;
    b = int'(addr & 32'hFFFF_FFFC);
    return known[b] && known[b+1] && known[b+2] && known[b+3];
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] addr);
    int b;
    if (!in_ram(addr)) return 32'h0;
    b = int'(addr & 32'hFFFF_FFFC);
    return {ref_b[b+3], ref_b[b+2], ref_b[b+1], ref_b[b]};
  endfunction

  // Store: check the same-cycle read still returns old data, then update the model.
  task automatic ram_wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel);
    int nl;
    int b;
    a = addr; wd = data; wsel = sel; we = 1'b1;
    #1;
    if (known_word(addr)) chk("wr_old_data", rd, ref_rd(addr));
    tick();
    we = 1'b0; wsel = 4'h0;
    if (in_ram(addr)) begin
      nl = $countones(sel);
      b  = int'(addr & 32'hFFFF_FFFC);
      for (int i = 0; i < 4; i++) begin
        if (sel[i]) begin
          if (nl == 1)      ref_b[b+i] = data[7:0];
          else if (nl == 2) ref_b[b+i] = data[8*(i%2) +: 8];
          else              ref_b[b+i] = data[8*i +: 8];
          known[b+i] = 1'b1;
        end
      end
    end
  endtask

  task automatic rd_chk(input logic [31:0] addr, input string tag);
    a = addr; we = 1'b0;
    #1;
    chk(tag, rd, ref_rd(addr));
  endtask

  task automatic cnt_chk(input string tag);
    a = MB; we = 1'b0;
    #1;
    chk({tag, "_lo"}, rd, cyc - base_cyc);
    a = MB + 32'h4;
    #1;
    chk({tag, "_hi"}, rd, 32'h0);
  endtask

  function automatic logic exp_tx(input logic [7:0] d, input int j);
    if (!UART_EN || j >= 10 * CPB) return 1'b1;
    if (j < CPB) return 1'b0;
    if (j < 9 * CPB) return d[(j - CPB) / CPB];
    return 1'b1;
  endfunction

  // Send one byte; cycle j=0 is the first cycle after the TXDATA write edge.
  task automatic send(input logic [7:0] d, input bit ovf_test, input int ncyc);
    logic [31:0] st;
    a = MB + 32'h8; wd = {24'h0, d}; wsel = 4'h1; we = 1'b1;
    #1;
    chk("tx_idle_line", {31'h0, uart_tx}, 32'h1);
    chk("txdata_reads0", rd, 32'h0);
    tick();
    for (int j = 0; j < ncyc; j++) begin
      we = 1'b0;
      a  = MB + 32'hC;
      if (ovf_test && j == 10) begin
        a = MB + 32'h8; wd = 32'h0000_00FF; we = 1'b1;
      end else if (ovf_test && j == 20) begin
        wd = 32'h2; we = 1'b1;
      end
      #1;
      chk("tx_line", {31'h0, uart_tx}, {31'h0, exp_tx(d, j)});
      st = {30'h0, UART_EN && ovf_test && j > 10 && j <= 20, UART_EN && j < 10 * CPB};
      if (a == MB + 32'h8) chk("txdata_reads0", rd, 32'h0);
      else chk("status", rd, st);
      tick();
    end
    we = 1'b0;
  endtask

  logic [3:0]  sels [8] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF, 4'h0};
  int unsigned w;
  logic [31:0] ad;
  logic [7:0]  rb;

  initial begin
    for (int i = 0; i < NB; i++) known[i] = 1'b0;
    reset = 1'b1; a = '0; wd = '0; we = 1'b0; wsel = '0;
    repeat (3) tick();
    chk("reset_tx", {31'h0, uart_tx}, 32'h1);
    reset = 1'b0;
    base_cyc = cyc;
    cnt_chk("reset_cycle");
    a = MB + 32'hC;
    #1;
    chk("reset_status", rd, 32'h0);

    repeat (100) tick();
    a = MB;
    #1;
    chk("cycle_after_100", rd, 32'd100);

    // Directed stores, lane steering and same-cycle read-old behaviour
    ram_wr(32'h10, 32'h0, 4'hF);
    ram_wr(32'h10, 32'hDEAD_BEEF, 4'hF);
    rd_chk(32'h10, "sw_read");
    chk("sw_const", rd, 32'hDEAD_BEEF);
    rd_chk(32'h13, "sw_read_lowbits");
    ram_wr(32'h10, 32'h0, 4'hF);
    ram_wr(32'h12, 32'h0000_00AB, 4'b0100);
    rd_chk(32'h10, "sb_read");
    chk("sb_const", rd, 32'h00AB_0000);
    ram_wr(32'h12, 32'h0000_1234, 4'b1100);
    rd_chk(32'h10, "sh_read");
    chk("sh_const", rd, 32'h1234_0000);
    ram_wr(32'h10, 32'hFFFF_FFFF, 4'h0);
    rd_chk(32'h10, "wsel0_nochange");

    // Boundaries and unmapped space
    ram_wr(32'(NB - 4), $urandom, 4'hF);
    ram_wr(32'(NB - 3), 32'h0000_005A, 4'b0010);
    rd_chk(32'(NB - 4), "last_word");
    rd_chk(32'(NB), "above_ram");
    ram_wr(32'(NB + 16), 32'hCAFE_F00D, 4'hF);
    ram_wr(32'h8000_0010, 32'hCAFE_F00D, 4'hF);
    rd_chk(32'h10, "unmapped_wr_ignored");
    rd_chk(32'h8000_0000, "unmapped_rd");
    chk("unmapped_const", rd, 32'h0);

    // Random traffic over a prefilled window
    for (int i = 0; i < 16; i++) ram_wr(32'(i * 4 + 64), $urandom, 4'hF);
    for (int it = 0; it < 80; it++) begin
      w  = $urandom_range(0, 15);
      ad = 32'(w * 4 + 64) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) ram_wr(ad, $urandom, sels[$urandom_range(0, 7)]);
      else rd_chk(ad, "rand_rd");
    end

    // Counter: writes ignored, keeps counting
    a = MB; wd = 32'h1234_5678; wsel = 4'hF; we = 1'b1;
    tick();
    we = 1'b0;
    repeat ($urandom_range(3, 40)) tick();
    cnt_chk("cycle_run");

    // UART: 0x55 with overflow/clear, then a random byte in the first idle cycle
    send(8'h55, 1'b1, 10 * CPB);
    rb = 8'($urandom);
    send(rb, 1'b0, 10 * CPB + 3);
    a = MB + 32'hC;
    #1;
    chk("status_idle", rd, 32'h0);

    // Reset in the middle of the data bits
    rb = 8'($urandom) & 8'hFE;
    send(rb, 1'b0, 3 * CPB);
    reset = 1'b1;
    tick();
    a = MB + 32'hC;
    #1;
    chk("midframe_reset_tx", {31'h0, uart_tx}, 32'h1);
    chk("midframe_reset_status", rd, 32'h0);
    reset = 1'b0;
    base_cyc = cyc;
    cnt_chk("cycle_after_reset");
    tick();
    cnt_chk("cycle_after_reset_1");
    chk("tx_stays_idle", {31'h0, uart_tx}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
